// File: rtl/er_dma_arbiter_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// er_dma_arbiter_pkg : shared types and helpers for the ER-aware DMA arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
package er_dma_arbiter_pkg;

  localparam int unsigned c_ADDR_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DEFER = 2'd1,
    GRANT = 2'd2,
    FORCE = 2'd3
  } arb_state_t;

  // Round-robin pick: the master rr points at if it requests, else the other one.
  function automatic logic [1:0] pick_winner(input logic [1:0] req, input logic rr);
    logic [1:0] w;
    w = 2'b00;
    if (req[rr]) begin
      w[rr] = 1'b1;
    end else if (req[~rr]) begin
      w[~rr] = 1'b1;
    end
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/er_dma_arbiter_range_cmp.sv
`default_nettype none
// ----------------------------------------------------------------------------
// er_range_cmp : combinational ER membership and ER entry-point detection
// Rev 1.0
// ----------------------------------------------------------------------------
module er_range_cmp
  import er_dma_arbiter_pkg::*;
(
  input  logic [c_ADDR_W-1:0] i_pc,
  input  logic [c_ADDR_W-1:0] i_er_min,
  input  logic [c_ADDR_W-1:0] i_er_max,
  output logic                o_in_er,
  output logic                o_is_fst
);

  // An inverted range (min > max) can never satisfy both bounds, so it is empty.
  assign o_in_er  = (i_pc >= i_er_min) && (i_pc <= i_er_max);
  assign o_is_fst = (i_pc == i_er_min);

endmodule
`default_nettype wire

// File: rtl/er_dma_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// er_dma_arbiter : two-master DMA arbiter that defers access while executing in ER
// Rev 1.0
// ----------------------------------------------------------------------------
module er_dma_arbiter
  import er_dma_arbiter_pkg::*;
#(
  parameter int unsigned     DW        = 8,
  parameter logic [DW-1:0]   MAX_DEFER = DW'(200)
)(
  input  logic                clk,
  input  logic                reset_n,
  input  logic [c_ADDR_W-1:0] pc,
  input  logic [c_ADDR_W-1:0] ER_min,
  input  logic [c_ADDR_W-1:0] ER_max,
  input  logic [1:0]          dma_req,
  output logic [1:0]          dma_gnt,
  output logic                dma_en,
  output logic                exec,
  output logic [DW-1:0]       defer_cnt,
  output logic                forced
);

  localparam logic [DW-1:0] c_LAST_DEFER = MAX_DEFER - DW'(1);

  arb_state_t    r_state;
  arb_state_t    w_state_nxt;
  logic [1:0]    r_gnt;
  logic [1:0]    w_gnt_nxt;
  logic          r_rr;
  logic          w_rr_nxt;
  logic [DW-1:0] r_cnt;
  logic [DW-1:0] w_cnt_nxt;
  logic          r_forced;
  logic          w_forced_nxt;
  logic          r_exec;
  logic          w_exec_nxt;

  logic          w_in_er;
  logic          w_is_fst;
  logic          w_any_req;
  logic          w_owner_rel;
  logic [1:0]    w_winner;

  er_range_cmp u_range_cmp (
    .i_pc     (pc),
    .i_er_min (ER_min),
    .i_er_max (ER_max),
    .o_in_er  (w_in_er),
    .o_is_fst (w_is_fst)
  );

  assign w_any_req   = |dma_req;
  assign w_winner    = pick_winner(dma_req, r_rr);
  assign w_owner_rel = ~|(dma_req & r_gnt);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_gnt    <= 2'b00;
      r_rr     <= 1'b0;
      r_cnt    <= '0;
      r_forced <= 1'b0;
      r_exec   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_gnt    <= w_gnt_nxt;
      r_rr     <= w_rr_nxt;
      r_cnt    <= w_cnt_nxt;
      r_forced <= w_forced_nxt;
      r_exec   <= w_exec_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_state_nxt = w_in_er ? DEFER : GRANT;
        end
      end
      DEFER: begin
        if (!w_any_req) begin
          w_state_nxt = IDLE;
        end else if (!w_in_er) begin
          w_state_nxt = GRANT;
        end else if (r_cnt == c_LAST_DEFER) begin
          w_state_nxt = FORCE;
        end
      end
      GRANT, FORCE: begin
        if (w_owner_rel) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_gnt_nxt    = r_gnt;
    w_rr_nxt     = r_rr;
    w_cnt_nxt    = r_cnt;
    w_forced_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (w_state_nxt == GRANT) begin
          w_gnt_nxt = w_winner;
        end
      end
      DEFER: begin
        case (w_state_nxt)
          IDLE: w_cnt_nxt = '0;
          GRANT: begin
            w_cnt_nxt = '0;
            w_gnt_nxt = w_winner;
          end
          FORCE: begin
            w_cnt_nxt    = MAX_DEFER;
            w_gnt_nxt    = w_winner;
            w_forced_nxt = 1'b1;
          end
          default: begin
            if (r_cnt != MAX_DEFER) begin
              w_cnt_nxt = r_cnt + DW'(1);
            end
          end
        endcase
      end
      GRANT, FORCE: begin
        // On release the pointer moves to the master that was not just served.
        if (w_state_nxt == IDLE) begin
          w_gnt_nxt = 2'b00;
          w_cnt_nxt = '0;
          w_rr_nxt  = r_gnt[0];
        end
      end
      default: w_gnt_nxt = 2'b00;
    endcase
  end

  // DMA touching ER revokes the proof; clearing takes priority over re-arming.
  always_comb begin
    w_exec_nxt = r_exec;
    if ((|r_gnt) && w_in_er) begin
      w_exec_nxt = 1'b0;
    end else if (w_is_fst && !(|r_gnt)) begin
      w_exec_nxt = 1'b1;
    end
  end

  assign dma_gnt   = r_gnt;
  assign dma_en    = |r_gnt;
  assign exec      = r_exec;
  assign defer_cnt = r_cnt;
  assign forced    = r_forced;

endmodule
`default_nettype wire

// File: tb/tb_er_dma_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_er_dma_arbiter : directed and randomized checks of er_dma_arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_er_dma_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] pc;
  logic [15:0] er_min;
  logic [15:0] er_max;
  logic [1:0]  req;

  logic [1:0]  d_gnt    [3];
  logic        d_en     [3];
  logic        d_exec   [3];
  logic [7:0]  d_cnt    [3];
  logic        d_forced [3];

  int checks = 0;
  int errors = 0;

  // Reference model: one entry per instance (MAX_DEFER 200, 5, 1)
  int         m_max   [3] = '{200, 5, 1};
  int         m_owner [3];
  int         m_cnt   [3];
  int         m_rr    [3];
  bit         m_defer [3];
  bit         m_exec  [3];
  bit         m_forced[3];
  logic [1:0] m_gnt   [3];

  always #5 clk = ~clk;

  er_dma_arbiter u_dut (
    .clk(clk), .reset_n(reset_n), .pc(pc), .ER_min(er_min), .ER_max(er_max),
    .dma_req(req), .dma_gnt(d_gnt[0]), .dma_en(d_en[0]), .exec(d_exec[0]),
    .defer_cnt(d_cnt[0]), .forced(d_forced[0])
  );

  er_dma_arbiter #(.DW(8), .MAX_DEFER(8'd5)) u_dut5 (
    .clk(clk), .reset_n(reset_n), .pc(pc), .ER_min(er_min), .ER_max(er_max),
    .dma_req(req), .dma_gnt(d_gnt[1]), .dma_en(d_en[1]), .exec(d_exec[1]),
    .defer_cnt(d_cnt[1]), .forced(d_forced[1])
  );

  er_dma_arbiter #(.DW(8), .MAX_DEFER(8'd1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .pc(pc), .ER_min(er_min), .ER_max(er_max),
    .dma_req(req), .dma_gnt(d_gnt[2]), .dma_en(d_en[2]), .exec(d_exec[2]),
    .defer_cnt(d_cnt[2]), .forced(d_forced[2])
  );

  function automatic int pick(input logic [1:0] r, input int rr);
    return r[rr] ? rr : 1 - rr;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_owner[k] = -1; m_cnt[k] = 0; m_rr[k] = 0; m_defer[k] = 0;
      m_exec[k] = 0; m_forced[k] = 0; m_gnt[k] = 2'b00;
    end
  endtask

  // Owner/waiting view of the arbiter, advanced once per rising edge
  task automatic model_step();
    bit in_er;
    bit fst;
    in_er = (pc >= er_min) && (pc <= er_max);
    fst   = (pc == er_min);
    for (int k = 0; k < 3; k++) begin
      if (m_gnt[k] != 2'b00 && in_er) m_exec[k] = 1'b0;
      else if (fst && m_gnt[k] == 2'b00) m_exec[k] = 1'b1;
      m_forced[k] = 1'b0;
      if (m_owner[k] >= 0) begin
        if (!req[m_owner[k]]) begin
          m_rr[k] = 1 - m_owner[k]; m_owner[k] = -1; m_cnt[k] = 0;
        end
      end else if (m_defer[k]) begin
        if (req == 2'b00) begin
          m_defer[k] = 0; m_cnt[k] = 0;
        end else if (!in_er) begin
          m_defer[k] = 0; m_cnt[k] = 0; m_owner[k] = pick(req, m_rr[k]);
        end else if (m_cnt[k] == m_max[k] - 1) begin
          m_defer[k] = 0; m_cnt[k] = m_max[k]; m_owner[k] = pick(req, m_rr[k]);
          m_forced[k] = 1;
        end else begin
          m_cnt[k]++;
        end
      end else if (req != 2'b00) begin
        if (in_er) begin
          m_defer[k] = 1; m_cnt[k] = 0;
        end else begin
          m_owner[k] = pick(req, m_rr[k]);
        end
      end
      m_gnt[k] = (m_owner[k] < 0) ? 2'b00 : 2'(1 << m_owner[k]);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req = 2'b00; pc = 16'h4000; er_min = 16'hE000; er_max = 16'hE0FF;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++; if (d_gnt[k] !== 2'b00) begin errors++; $display("FAIL reset_gnt[%0d] got %b exp 00", k, d_gnt[k]); end
      checks++; if (d_en[k] !== 1'b0) begin errors++; $display("FAIL reset_en[%0d] got %b exp 0", k, d_en[k]); end
      checks++; if (d_exec[k] !== 1'b0) begin errors++; $display("FAIL reset_exec[%0d] got %b exp 0", k, d_exec[k]); end
      checks++; if (d_cnt[k] !== 8'd0) begin errors++; $display("FAIL reset_cnt[%0d] got %0d exp 0", k, d_cnt[k]); end
      checks++; if (d_forced[k] !== 1'b0) begin errors++; $display("FAIL reset_forced[%0d] got %b exp 0", k, d_forced[k]); end
    end
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_basic_grant();
    req = 2'b01; tick();
    checks++; if (d_gnt[0] !== 2'b01) begin errors++; $display("FAIL basic_gnt got %b exp 01", d_gnt[0]); end
    checks++; if (d_en[0] !== 1'b1) begin errors++; $display("FAIL basic_en got %b exp 1", d_en[0]); end
    tick();
    checks++; if (d_gnt[0] !== 2'b01) begin errors++; $display("FAIL basic_hold got %b exp 01", d_gnt[0]); end
    req = 2'b00; tick();
    checks++; if (d_gnt[0] !== 2'b00) begin errors++; $display("FAIL basic_release got %b exp 00", d_gnt[0]); end
    checks++; if (d_en[0] !== 1'b0) begin errors++; $display("FAIL basic_en_off got %b exp 0", d_en[0]); end
    req = 2'b11; tick();
    checks++; if (d_gnt[0] !== 2'b10) begin errors++; $display("FAIL basic_rr_next got %b exp 10", d_gnt[0]); end
    req = 2'b00; tick();
    checks++; if (d_gnt[0] !== 2'b00) begin errors++; $display("FAIL basic_release2 got %b exp 00", d_gnt[0]); end
  endtask

  task automatic test_round_robin();
    logic [1:0] rq [10] = '{2'b11, 2'b11, 2'b11, 2'b10, 2'b11, 2'b11, 2'b11, 2'b01, 2'b11, 2'b00};
    logic [1:0] eg [10] = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01, 2'b00};
    for (int i = 0; i < 10; i++) begin
      req = rq[i]; tick();
      checks++; if (d_gnt[0] !== eg[i]) begin errors++; $display("FAIL rr_step%0d got %b exp %b", i, d_gnt[0], eg[i]); end
      checks++; if (d_en[0] !== (|eg[i])) begin errors++; $display("FAIL rr_en%0d got %b exp %b", i, d_en[0], |eg[i]); end
    end
  endtask

  task automatic test_deferral();
    pc = 16'hE000; req = 2'b00; tick();
    checks++; if (d_exec[0] !== 1'b1) begin errors++; $display("FAIL defer_exec_set got %b exp 1", d_exec[0]); end
    pc = 16'hE010; req = 2'b10; tick();
    checks++; if (d_gnt[0] !== 2'b00) begin errors++; $display("FAIL defer_no_gnt got %b exp 00", d_gnt[0]); end
    checks++; if (d_cnt[0] !== 8'd0) begin errors++; $display("FAIL defer_cnt0 got %0d exp 0", d_cnt[0]); end
    for (int i = 1; i <= 10; i++) begin
      tick();
      checks++; if (d_cnt[0] !== 8'(i)) begin errors++; $display("FAIL defer_cnt got %0d exp %0d", d_cnt[0], i); end
      checks++; if (d_gnt[0] !== 2'b00) begin errors++; $display("FAIL defer_hold_gnt got %b exp 00", d_gnt[0]); end
    end
    pc = 16'h4000; tick();
    checks++; if (d_gnt[0] !== 2'b10) begin errors++; $display("FAIL defer_exit_gnt got %b exp 10", d_gnt[0]); end
    checks++; if (d_forced[0] !== 1'b0) begin errors++; $display("FAIL defer_forced got %b exp 0", d_forced[0]); end
    checks++; if (d_cnt[0] !== 8'd0) begin errors++; $display("FAIL defer_cnt_clr got %0d exp 0", d_cnt[0]); end
    checks++; if (d_exec[0] !== 1'b1) begin errors++; $display("FAIL defer_exec_kept got %b exp 1", d_exec[0]); end
    req = 2'b00; tick();
    checks++; if (d_gnt[0] !== 2'b00) begin errors++; $display("FAIL defer_release got %b exp 00", d_gnt[0]); end
  endtask

  task automatic test_forced();
    logic [1:0] eg5, eg1;
    pc = 16'hE000; req = 2'b00; tick();
    checks++; if (d_exec[1] !== 1'b1) begin errors++; $display("FAIL force_pre_exec5 got %b exp 1", d_exec[1]); end
    checks++; if (d_exec[2] !== 1'b1) begin errors++; $display("FAIL force_pre_exec1 got %b exp 1", d_exec[2]); end
    pc = 16'hE020; req = 2'b01;
    for (int i = 0; i < 7; i++) begin
      tick();
      eg5 = (i >= 5) ? 2'b01 : 2'b00;
      eg1 = (i >= 1) ? 2'b01 : 2'b00;
      checks++; if (d_gnt[1] !== eg5) begin errors++; $display("FAIL force5_gnt c%0d got %b exp %b", i, d_gnt[1], eg5); end
      checks++; if (d_forced[1] !== (i == 5)) begin errors++; $display("FAIL force5_pulse c%0d got %b exp %b", i, d_forced[1], i == 5); end
      checks++; if (d_cnt[1] !== 8'((i >= 5) ? 5 : i)) begin errors++; $display("FAIL force5_cnt c%0d got %0d exp %0d", i, d_cnt[1], (i >= 5) ? 5 : i); end
      checks++; if (d_exec[1] !== (i < 6)) begin errors++; $display("FAIL force5_exec c%0d got %b exp %b", i, d_exec[1], i < 6); end
      checks++; if (d_gnt[2] !== eg1) begin errors++; $display("FAIL force1_gnt c%0d got %b exp %b", i, d_gnt[2], eg1); end
      checks++; if (d_forced[2] !== (i == 1)) begin errors++; $display("FAIL force1_pulse c%0d got %b exp %b", i, d_forced[2], i == 1); end
      checks++; if (d_cnt[2] !== 8'((i >= 1) ? 1 : 0)) begin errors++; $display("FAIL force1_cnt c%0d got %0d", i, d_cnt[2]); end
      checks++; if (d_exec[2] !== (i < 2)) begin errors++; $display("FAIL force1_exec c%0d got %b exp %b", i, d_exec[2], i < 2); end
    end
    req = 2'b00; tick();
    checks++; if (d_gnt[1] !== 2'b00) begin errors++; $display("FAIL force5_release got %b exp 00", d_gnt[1]); end
    checks++; if (d_cnt[1] !== 8'd0) begin errors++; $display("FAIL force5_cnt_clr got %0d exp 0", d_cnt[1]); end
    checks++; if (d_cnt[2] !== 8'd0) begin errors++; $display("FAIL force1_cnt_clr got %0d exp 0", d_cnt[2]); end
  endtask

  task automatic test_exec_race();
    pc = 16'h4000; req = 2'b01; tick();
    checks++; if (d_gnt[0] !== 2'b01) begin errors++; $display("FAIL race_gnt got %b exp 01", d_gnt[0]); end
    pc = 16'hE000; tick();
    checks++; if (d_exec[0] !== 1'b0) begin errors++; $display("FAIL race_clear got %b exp 0", d_exec[0]); end
    tick();
    checks++; if (d_exec[0] !== 1'b0) begin errors++; $display("FAIL race_clear_wins got %b exp 0", d_exec[0]); end
    req = 2'b00; tick();
    checks++; if (d_gnt[0] !== 2'b00) begin errors++; $display("FAIL race_release got %b exp 00", d_gnt[0]); end
    checks++; if (d_exec[0] !== 1'b0) begin errors++; $display("FAIL race_last_clear got %b exp 0", d_exec[0]); end
    tick();
    checks++; if (d_exec[0] !== 1'b1) begin errors++; $display("FAIL race_reset_exec got %b exp 1", d_exec[0]); end
  endtask

  task automatic test_boundaries();
    pc = 16'hE0FF; req = 2'b01; tick();
    checks++; if (d_gnt[0] !== 2'b00) begin errors++; $display("FAIL bnd_max_inside got %b exp 00", d_gnt[0]); end
    tick();
    checks++; if (d_cnt[0] !== 8'd1) begin errors++; $display("FAIL bnd_max_cnt got %0d exp 1", d_cnt[0]); end
    pc = 16'hE100; tick();
    checks++; if (d_gnt[0] !== 2'b01) begin errors++; $display("FAIL bnd_max_plus1 got %b exp 01", d_gnt[0]); end
    req = 2'b00; tick();
    er_min = 16'hE100; er_max = 16'hE000; pc = 16'hE080; req = 2'b10; tick();
    checks++; if (d_gnt[0] !== 2'b10) begin errors++; $display("FAIL bnd_empty_gnt got %b exp 10", d_gnt[0]); end
    pc = 16'hE100; tick();
    checks++; if (d_exec[0] !== 1'b1) begin errors++; $display("FAIL bnd_empty_exec got %b exp 1", d_exec[0]); end
    checks++; if (d_gnt[0] !== 2'b10) begin errors++; $display("FAIL bnd_empty_hold got %b exp 10", d_gnt[0]); end
    req = 2'b00; tick();
    er_min = 16'hE000; er_max = 16'hE0FF; pc = 16'h4000;
  endtask

  task automatic test_async_reset();
    req = 2'b01; tick();
    req = 2'b00; tick();
    pc = 16'hE000; tick();
    pc = 16'h4000; req = 2'b10; tick();
    checks++; if (d_gnt[0] !== 2'b10) begin errors++; $display("FAIL arst_pre_gnt got %b exp 10", d_gnt[0]); end
    checks++; if (d_exec[0] !== 1'b1) begin errors++; $display("FAIL arst_pre_exec got %b exp 1", d_exec[0]); end
    #2;
    reset_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++; if (d_gnt[k] !== 2'b00) begin errors++; $display("FAIL arst_gnt[%0d] got %b exp 00", k, d_gnt[k]); end
      checks++; if (d_en[k] !== 1'b0) begin errors++; $display("FAIL arst_en[%0d] got %b exp 0", k, d_en[k]); end
      checks++; if (d_exec[k] !== 1'b0) begin errors++; $display("FAIL arst_exec[%0d] got %b exp 0", k, d_exec[k]); end
      checks++; if (d_cnt[k] !== 8'd0) begin errors++; $display("FAIL arst_cnt[%0d] got %0d exp 0", k, d_cnt[k]); end
      checks++; if (d_forced[k] !== 1'b0) begin errors++; $display("FAIL arst_forced[%0d] got %b exp 0", k, d_forced[k]); end
    end
    model_reset();
    @(negedge clk);
    req = 2'b11;
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      checks++; if (d_gnt[k] !== 2'b01) begin errors++; $display("FAIL arst_rr0[%0d] got %b exp 01", k, d_gnt[k]); end
    end
    req = 2'b00; tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 49) == 0) begin
        er_min = 16'($urandom_range(16'h1000, 16'hF000));
        er_max = ($urandom_range(0, 7) == 0) ? er_min - 16'h0010 : er_min + 16'($urandom_range(0, 255));
      end
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 6))
          0: pc = er_min - 16'd1;
          1: pc = er_min;
          2: pc = er_min + 16'd1;
          3: pc = er_max;
          4: pc = er_max + 16'd1;
          5: pc = er_min + 16'($urandom_range(0, 64));
          default: pc = 16'($urandom);
        endcase
      end
      if ($urandom_range(0, 5) == 0) req[0] = ~req[0];
      if ($urandom_range(0, 5) == 0) req[1] = ~req[1];
      tick();
      for (int k = 0; k < 3; k++) begin
        checks++; if (d_gnt[k] !== m_gnt[k]) begin errors++; $display("FAIL rnd_gnt[%0d] n%0d got %b exp %b", k, n, d_gnt[k], m_gnt[k]); end
        checks++; if (d_en[k] !== (|m_gnt[k])) begin errors++; $display("FAIL rnd_en[%0d] n%0d got %b exp %b", k, n, d_en[k], |m_gnt[k]); end
        checks++; if (d_exec[k] !== m_exec[k]) begin errors++; $display("FAIL rnd_exec[%0d] n%0d got %b exp %b", k, n, d_exec[k], m_exec[k]); end
        checks++; if (d_cnt[k] !== 8'(m_cnt[k])) begin errors++; $display("FAIL rnd_cnt[%0d] n%0d got %0d exp %0d", k, n, d_cnt[k], m_cnt[k]); end
        checks++; if (d_forced[k] !== m_forced[k]) begin errors++; $display("FAIL rnd_forced[%0d] n%0d got %b exp %b", k, n, d_forced[k], m_forced[k]); end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_grant();
    test_round_robin();
    test_deferral();
    test_forced();
    test_exec_race();
    test_boundaries();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
